// File: rtl/alu_seq_if.sv
// alu_seq_if
// Bundles the request, ALU-control and result signals of the alu_seq
// micro-sequencer.
//   slave  : sequencer side (accepts requests, drives ALU controls, returns result)
//   master : environment side (issues requests, models the ALU, consumes result)
// Signals:
//   req_valid/req_ready/req_fn/req_a/req_b : request handshake and operands
//   alu_op/alu_la/alu_lb/alu_fn/alu_ci/alu_l/alu_h/alu_res_oe : ALU controls
//   alu_result/alu_zero/alu_carry : ALU outputs sampled by the sequencer
//   res_valid/res_data/flags : one-cycle result pulse, result byte, {Z,N,H,C,0000}
interface alu_seq_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_fn;
    logic [7:0] req_a;
    logic [7:0] req_b;

    logic [7:0] alu_op;
    logic       alu_la;
    logic       alu_lb;
    logic [3:0] alu_fn;
    logic       alu_ci;
    logic       alu_l;
    logic       alu_h;
    logic       alu_res_oe;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_carry;

    logic       res_valid;
    logic [7:0] res_data;
    logic [7:0] flags;

    modport slave (
        input  req_valid, req_fn, req_a, req_b,
        input  alu_result, alu_zero, alu_carry,
        output req_ready,
        output alu_op, alu_la, alu_lb, alu_fn, alu_ci, alu_l, alu_h, alu_res_oe,
        output res_valid, res_data, flags
    );

    modport master (
        output req_valid, req_fn, req_a, req_b,
        output alu_result, alu_zero, alu_carry,
        input  req_ready,
        input  alu_op, alu_la, alu_lb, alu_fn, alu_ci, alu_l, alu_h, alu_res_oe,
        input  res_valid, res_data, flags
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq
// Micro-sequencer in front of the 8-bit nibble-serial ALU. Accepts one
// request (ADD, ADC, SUB, SBC, AND, XOR, OR, CP), walks the ALU through
// load-A, low-nibble and high-nibble cycles, and returns the result byte
// with Game Boy style flags {Z,N,H,C,4'b0} on a one-cycle res_valid pulse.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : alu_seq_if.slave (request handshake, ALU controls, result)
// Configuration macro:
//   ALU_SEQ_CARRY_OPS_EN : when defined, ADC/SBC consume the stored C flag;
//                          when undefined, ADC == ADD and SBC == SUB.
module alu_seq (
    input  logic      clk,
    input  logic      reset,
    alu_seq_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LDA  = 2'd1;
    localparam logic [1:0] ST_LO   = 2'd2;
    localparam logic [1:0] ST_HI   = 2'd3;

    localparam logic [2:0] FN_ADD = 3'd0;
    localparam logic [2:0] FN_ADC = 3'd1;
    localparam logic [2:0] FN_SUB = 3'd2;
    localparam logic [2:0] FN_SBC = 3'd3;
    localparam logic [2:0] FN_AND = 3'd4;
    localparam logic [2:0] FN_XOR = 3'd5;
    localparam logic [2:0] FN_OR  = 3'd6;
    localparam logic [2:0] FN_CP  = 3'd7;

    logic [1:0] state;
    logic [2:0] fn_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic       half_q;

    logic       res_valid_q;
    logic [7:0] res_data_q;
    logic [7:0] flags_q;

    logic [3:0] fn_sel;
    logic       ci_sel;
    logic       is_add;
    logic       is_sub;
    logic       h_next;
    logic       c_next;

    // Operation class: add-type and subtract-type ops share flag rules.
    assign is_add = (fn_q == FN_ADD) || (fn_q == FN_ADC);
    assign is_sub = (fn_q == FN_SUB) || (fn_q == FN_SBC) || (fn_q == FN_CP);

    // ALU function encoding {r,s,v,ne} and carry-in for the low nibble.
    // The stored C flag can only change at the end of HI, so reading it
    // during LO yields the value that was current at accept time.
    always_comb begin
        fn_sel = 4'b0000;
        ci_sel = 1'b0;
        case (fn_q)
            FN_AND: fn_sel = 4'b0100;
            FN_OR:  fn_sel = 4'b0010;
            FN_XOR: fn_sel = 4'b1000;
            FN_ADD: ci_sel = 1'b0;
            FN_ADC: begin
`ifdef ALU_SEQ_CARRY_OPS_EN
                ci_sel = flags_q[4];
`else
                ci_sel = 1'b0;
`endif
            end
            FN_SUB, FN_CP: begin
                fn_sel = 4'b0001;
                ci_sel = 1'b1;
            end
            FN_SBC: begin
                fn_sel = 4'b0001;
`ifdef ALU_SEQ_CARRY_OPS_EN
                ci_sel = ~flags_q[4];
`else
                ci_sel = 1'b1;
`endif
            end
            default: begin
                fn_sel = 4'b0000;
                ci_sel = 1'b0;
            end
        endcase
    end

    // Half-carry and carry flags: subtraction reports borrow, which is the
    // inverse of the ALU's carry-out; AND forces H=1 as on the Game Boy.
    always_comb begin
        h_next = 1'b0;
        c_next = 1'b0;
        if (is_add) begin
            h_next = half_q;
            c_next = bus.alu_carry;
        end else if (is_sub) begin
            h_next = ~half_q;
            c_next = ~bus.alu_carry;
        end else if (fn_q == FN_AND) begin
            h_next = 1'b1;
        end
    end

    // Sequencer state, operand latches and registered result/flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            fn_q        <= 3'd0;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            half_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
            flags_q     <= 8'h00;
        end else begin
            res_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        fn_q  <= bus.req_fn;
                        a_q   <= bus.req_a;
                        b_q   <= bus.req_b;
                        state <= ST_LDA;
                    end
                end
                ST_LDA: begin
                    state <= ST_LO;
                end
                ST_LO: begin
                    half_q <= bus.alu_carry;
                    state  <= ST_HI;
                end
                ST_HI: begin
                    res_valid_q <= 1'b1;
                    // CP only compares: the flags come from A-B but A is returned.
                    res_data_q  <= (fn_q == FN_CP) ? a_q : bus.alu_result;
                    flags_q     <= {bus.alu_zero, is_sub, h_next, c_next, 4'b0000};
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ALU control lines decoded from the current phase; all zero in IDLE.
    always_comb begin
        bus.alu_op     = 8'h00;
        bus.alu_la     = 1'b0;
        bus.alu_lb     = 1'b0;
        bus.alu_fn     = 4'b0000;
        bus.alu_ci     = 1'b0;
        bus.alu_l      = 1'b0;
        bus.alu_h      = 1'b0;
        bus.alu_res_oe = 1'b0;
        case (state)
            ST_LDA: begin
                bus.alu_op = a_q;
                bus.alu_la = 1'b1;
            end
            ST_LO: begin
                bus.alu_op = b_q;
                bus.alu_lb = 1'b1;
                bus.alu_l  = 1'b1;
                bus.alu_fn = fn_sel;
                bus.alu_ci = ci_sel;
            end
            ST_HI: begin
                bus.alu_h      = 1'b1;
                bus.alu_res_oe = 1'b1;
                bus.alu_fn     = fn_sel;
            end
            default: begin
                bus.alu_op = 8'h00;
            end
        endcase
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq
// Self-checking bench for alu_seq. A behavioural nibble-serial ALU answers
// the sequencer's control lines, and a byte-level arithmetic reference model
// predicts result and flags for every operation.
module tb_alu_seq;

`ifdef ALU_SEQ_CARRY_OPS_EN
    localparam bit CARRY_OPS = 1'b1;
`else
    localparam bit CARRY_OPS = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [7:0] model_flags;

    alu_seq_if bus ();

    alu_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: A latched on la, B on lb, low nibble result and carry
    // kept for the high-nibble phase.
    logic [7:0] alu_a_q, alu_b_q;
    logic [3:0] alu_lo_q;
    logic       alu_lc_q;
    logic [7:0] alu_b_eff;
    logic [4:0] alu_lo_calc, alu_hi_calc;

    function automatic logic [4:0] nib(input logic [3:0] f, input logic [3:0] x,
                                       input logic [3:0] y, input logic cin);
        logic [4:0] s;
        case (f)
            4'b1000: s = {1'b0, x ^ y};
            4'b0100: s = {1'b0, x & y};
            4'b0010: s = {1'b0, x | y};
            default: s = {1'b0, x} + {1'b0, (f[0] ? ~y : y)} + {4'b0, cin};
        endcase
        return s;
    endfunction

    always_comb begin
        alu_b_eff   = bus.alu_lb ? bus.alu_op : alu_b_q;
        alu_lo_calc = nib(bus.alu_fn, alu_a_q[3:0], alu_b_eff[3:0], bus.alu_ci);
        alu_hi_calc = nib(bus.alu_fn, alu_a_q[7:4], alu_b_q[7:4], alu_lc_q);
        bus.alu_result = bus.alu_res_oe ? {alu_hi_calc[3:0], alu_lo_q} : 8'h00;
        bus.alu_zero   = ({alu_hi_calc[3:0], alu_lo_q} == 8'h00);
        bus.alu_carry  = bus.alu_l ? alu_lo_calc[4] : (bus.alu_h ? alu_hi_calc[4] : 1'b0);
    end

    always_ff @(posedge clk) begin
        if (bus.alu_la) alu_a_q <= bus.alu_op;
        if (bus.alu_lb) alu_b_q <= bus.alu_op;
        if (bus.alu_l) begin
            alu_lo_q <= alu_lo_calc[3:0];
            alu_lc_q <= alu_lo_calc[4];
        end
    end

    // Byte-level reference: returns {res_data, flags}.
    function automatic logic [15:0] ref_op(input logic [2:0] f, input logic [7:0] a,
                                           input logic [7:0] b, input logic cflag);
        int ai, bi, cin, r;
        logic [7:0] res, out;
        logic z, n, h, c;
        ai = int'(a); bi = int'(b); cin = 0;
        n = 1'b0; h = 1'b0; c = 1'b0;
        case (f)
            3'd0, 3'd1: begin
                if (f == 3'd1 && CARRY_OPS) cin = int'(cflag);
                r = ai + bi + cin;
                res = r[7:0];
                h = ((ai % 16) + (bi % 16) + cin) > 15;
                c = r > 255;
            end
            3'd2, 3'd3, 3'd7: begin
                if (f == 3'd3 && CARRY_OPS) cin = int'(cflag);
                r = ai - bi - cin;
                res = r[7:0];
                h = (ai % 16) < ((bi % 16) + cin);
                c = ai < (bi + cin);
                n = 1'b1;
            end
            3'd4: begin res = a & b; h = 1'b1; end
            3'd5: res = a ^ b;
            default: res = a | b;
        endcase
        z = (res == 8'h00);
        out = (f == 3'd7) ? a : res;
        return {out, z, n, h, c, 4'b0000};
    endfunction

    function automatic logic [3:0] exp_fn(input logic [2:0] f);
        case (f)
            3'd4: return 4'b0100;
            3'd5: return 4'b1000;
            3'd6: return 4'b0010;
            3'd2, 3'd3, 3'd7: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic exp_ci(input logic [2:0] f, input logic cflag);
        case (f)
            3'd1: return CARRY_OPS ? cflag : 1'b0;
            3'd2, 3'd7: return 1'b1;
            3'd3: return CARRY_OPS ? ~cflag : 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Runs one operation starting at a negedge with the sequencer idle and
    // ends at the negedge of the result cycle. When nxt is set, the next
    // request is driven (valid held high) right after the accept, so it is
    // ignored while busy and accepted at the end of the result cycle.
    task automatic run_op(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                          input bit pre_driven, input bit nxt,
                          input logic [2:0] nf, input logic [7:0] na, input logic [7:0] nb);
        logic [15:0] exp;
        logic cflag;
        cflag = model_flags[4];
        exp = ref_op(f, a, b, cflag);
        if (!pre_driven) begin
            bus.req_valid = 1'b1; bus.req_fn = f; bus.req_a = a; bus.req_b = b;
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL accept_ready got=%b want=1", bus.req_ready);
        end
        @(negedge clk);
        if (nxt) begin
            bus.req_valid = 1'b1; bus.req_fn = nf; bus.req_a = na; bus.req_b = nb;
        end else begin
            bus.req_valid = 1'b0; bus.req_fn = 3'($urandom); bus.req_a = 8'($urandom); bus.req_b = 8'($urandom);
        end
        checks++;
        if ({bus.req_ready, bus.alu_la, bus.alu_l, bus.res_valid, bus.alu_op} !== {4'b0100, a}) begin
            failures++;
            $display("[TB] FAIL lda_phase got rdy/la/l/rv/op=%b%b%b%b/%h want 0100/%h",
                     bus.req_ready, bus.alu_la, bus.alu_l, bus.res_valid, bus.alu_op, a);
        end
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.alu_lb, bus.alu_l, bus.alu_h, bus.alu_fn, bus.alu_ci, bus.alu_op}
            !== {4'b0110, exp_fn(f), exp_ci(f, cflag), b}) begin
            failures++;
            $display("[TB] FAIL lo_phase fn=%0d got rdy/lb/l/h/fn/ci/op=%b%b%b%b/%b/%b/%h want 0110/%b/%b/%h",
                     f, bus.req_ready, bus.alu_lb, bus.alu_l, bus.alu_h, bus.alu_fn, bus.alu_ci,
                     bus.alu_op, exp_fn(f), exp_ci(f, cflag), b);
        end
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.alu_h, bus.alu_res_oe, bus.alu_l, bus.res_valid, bus.alu_fn}
            !== {5'b01100, exp_fn(f)}) begin
            failures++;
            $display("[TB] FAIL hi_phase got rdy/h/oe/l/rv/fn=%b%b%b%b%b/%b want 01100/%b",
                     bus.req_ready, bus.alu_h, bus.alu_res_oe, bus.alu_l, bus.res_valid,
                     bus.alu_fn, exp_fn(f));
        end
        @(negedge clk);
        checks++;
        if ({bus.res_valid, bus.req_ready, bus.alu_la, bus.res_data, bus.flags} !== {3'b110, exp}) begin
            failures++;
            $display("[TB] FAIL result fn=%0d a=%h b=%h got rv/rdy/la=%b%b%b data=%h flags=%h want 110 data=%h flags=%h",
                     f, a, b, bus.res_valid, bus.req_ready, bus.alu_la, bus.res_data, bus.flags,
                     exp[15:8], exp[7:0]);
        end
        model_flags = exp[7:0];
        if (!nxt) bus.req_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        checks++;
        if ({bus.res_valid, bus.req_ready} !== 2'b01) begin
            failures++; $display("[TB] FAIL idle_pulse got rv/rdy=%b%b want 01", bus.res_valid, bus.req_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.res_valid, bus.res_data, bus.flags, bus.alu_op, bus.alu_la, bus.alu_lb,
             bus.alu_fn, bus.alu_ci, bus.alu_l, bus.alu_h, bus.alu_res_oe} !== {2'b10, 24'h0, 10'h0}) begin
            failures++;
            $display("[TB] FAIL reset_state got rdy=%b rv=%b data=%h flags=%h op=%h fn=%b",
                     bus.req_ready, bus.res_valid, bus.res_data, bus.flags, bus.alu_op, bus.alu_fn);
        end
        reset = 1'b0;
        model_flags = 8'h00;
        idle_cycle();
    endtask

    task automatic test_directed();
        run_op(3'd5, 8'h5A, 8'hFF, 0, 0, 0, 0, 0);
        checks++;
        if ({bus.res_data, bus.flags} !== 16'hA500) begin
            failures++; $display("[TB] FAIL xor_plan got %h/%h want a5/00", bus.res_data, bus.flags);
        end
        idle_cycle();
        run_op(3'd0, 8'hFF, 8'h01, 0, 0, 0, 0, 0);
        checks++;
        if ({bus.res_data, bus.flags} !== 16'h00B0) begin
            failures++; $display("[TB] FAIL add_plan got %h/%h want 00/b0", bus.res_data, bus.flags);
        end
        run_op(3'd0, 8'h0F, 8'h01, 0, 0, 0, 0, 0);
        run_op(3'd2, 8'h10, 8'h20, 0, 0, 0, 0, 0);
        checks++;
        if ({bus.res_data, bus.flags} !== 16'hF050) begin
            failures++; $display("[TB] FAIL sub_plan got %h/%h want f0/50", bus.res_data, bus.flags);
        end
        run_op(3'd1, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        checks++;
        if (bus.res_data !== (CARRY_OPS ? 8'h01 : 8'h00)) begin
            failures++; $display("[TB] FAIL adc_plan got %h want %h", bus.res_data, CARRY_OPS ? 8'h01 : 8'h00);
        end
        run_op(3'd7, 8'h10, 8'h10, 0, 0, 0, 0, 0);
        checks++;
        if ({bus.res_data, bus.flags} !== 16'h10C0) begin
            failures++; $display("[TB] FAIL cp_plan got %h/%h want 10/c0", bus.res_data, bus.flags);
        end
        run_op(3'd4, 8'hF0, 8'h0F, 0, 0, 0, 0, 0);
        idle_cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 0, 0, 0, 0, 0);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        logic [2:0] f0, f1, f2;
        logic [7:0] a0, b0, a1, b1, a2, b2;
        f0 = 3'($urandom); a0 = 8'($urandom); b0 = 8'($urandom);
        f1 = 3'd3;         a1 = 8'($urandom); b1 = 8'($urandom);
        f2 = 3'd1;         a2 = 8'($urandom); b2 = 8'($urandom);
        run_op(f0, a0, b0, 0, 1, f1, a1, b1);
        run_op(f1, a1, b1, 1, 1, f2, a2, b2);
        run_op(f2, a2, b2, 1, 0, 0, 0, 0);
        idle_cycle();
    endtask

    task automatic test_reset_mid_op();
        bus.req_valid = 1'b1; bus.req_fn = 3'd0; bus.req_a = 8'hFF; bus.req_b = 8'h01;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.alu_l !== 1'b1) begin
            failures++; $display("[TB] FAIL rst_reach_lo got alu_l=%b want 1", bus.alu_l);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.req_ready, bus.res_valid, bus.flags, bus.alu_l, bus.alu_lb, bus.alu_op} !== {2'b10, 8'h00, 2'b00, 8'h00}) begin
            failures++;
            $display("[TB] FAIL rst_mid_op got rdy=%b rv=%b flags=%h l=%b lb=%b op=%h want 1 0 00 0 0 00",
                     bus.req_ready, bus.res_valid, bus.flags, bus.alu_l, bus.alu_lb, bus.alu_op);
        end
        @(negedge clk);
        reset = 1'b0;
        model_flags = 8'h00;
        for (int i = 0; i < 6; i++) idle_cycle();
        run_op(3'd1, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        idle_cycle();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        model_flags = 8'h00;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_fn = 3'd0;
        bus.req_a = 8'h00;
        bus.req_b = 8'h00;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Micro-sequencer that sits directly upstream of the 8-bit nibble-serial ALU. It accepts one 8-bit arithmetic/logic request (ADD, ADC, SUB, SBC, AND, XOR, OR, CP) and drives the ALU control lines over three cycles: load A, low nibble, high nibble plus result out. It samples the ALU's `carry`, `zero` and `result` outputs to build the Game Boy flag byte (Z N H C) and returns result and flags with a one-cycle valid pulse.

## Interface
Parameters: none.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer idle; request accepted when `req_valid && req_ready` at a rising edge.
- `req_fn` in 3: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP.
- `req_a`, `req_b` in 8: operands A and B.
- `alu_op` out 8: ALU operand bus.
- `alu_la`, `alu_lb` out 1: load ALU A / B latch.
- `alu_fn` out 4: ALU function select `{r,s,v,ne}`.
- `alu_ci` out 1: ALU carry-in.
- `alu_l`, `alu_h` out 1: low / high nibble phase.
- `alu_res_oe` out 1: select ALU result onto its output (0 = shifter path).
- `alu_result` in 8, `alu_zero` in 1, `alu_carry` in 1: ALU outputs.
- `res_valid` out 1: one-cycle result pulse.
- `res_data` out 8: result; for CP, equals A.
- `flags` out 8: `{Z,N,H,C,4'b0}`, held until the next completed operation.

## Operation
FSM: IDLE → LDA → LO → HI → IDLE.
- IDLE: `req_ready`=1 and all ALU controls are 0. On accept, latch fn/A/B and go to LDA.
- LDA: `alu_op`=A, `alu_la`=1.
- LO: `alu_op`=B, `alu_lb`=1, `alu_l`=1, `alu_fn`/`alu_ci` per function. At the end of the cycle, latch `alu_carry` as raw half-carry.
- HI: `alu_h`=1, `alu_res_oe`=1, same `alu_fn`. At the end of the cycle, register `res_data`, `flags` and `res_valid`=1.

Function encodings:
- AND `{0,1,0,0}`, OR `{0,0,1,0}`, XOR `{1,0,0,0}`: `ci`=0.
- ADD/ADC `{0,0,0,0}`: `ci`=0 (ADD) or stored C (ADC).
- SUB/CP `{0,0,0,1}`: `ci`=1.
- SBC `{0,0,0,1}`: `ci`=!C.

Flags:
- Z = `alu_zero` in all cases.
- N = 1 for SUB, SBC and CP; otherwise 0.
- Add ops: H = raw half-carry, C = `alu_carry`.
- Subtract ops: H = !raw half-carry, C = !`alu_carry` (borrow).
- AND: H=1, C=0. OR/XOR: H=0, C=0.
- CP: `res_data`=A and flags are updated.

Reset values: `req_ready`=1 (state IDLE), `res_valid`=0, `res_data`=0x00, `flags`=0x00, all ALU controls 0.

## Timing
- Accept at edge N. LDA occupies cycle N+1, LO N+2, HI N+3.
- `res_valid` is high for cycle N+4 only; `req_ready` is high again in N+4, so a back-to-back accept is possible at the end of N+4.
- Throughput: one operation per 4 cycles.
- `req_*` are ignored while `req_ready`=0. There is no back-pressure on the result side.
- ADC/SBC use the C value of `flags` at accept time. An accept coinciding with `res_valid` sees the freshly registered flags.
- Reset asserted mid-operation: immediate return to IDLE, all outputs to reset values, in-flight operation discarded, and no `res_valid` after release.

## Configuration
- `ALU_SEQ_CARRY_OPS_EN` defined: ADC/SBC use the stored carry as described.
- Not defined: ADC behaves exactly as ADD and SBC exactly as SUB (`ci` independent of C), and the carry-feedback path is removed.

## Test plan
- XOR A=0x5A B=0xFF → `res_valid` at N+4, `res_data`=0xA5, `flags`=0x00; in LO `alu_fn`=4'b1000, `alu_l`=1; in HI `alu_h`=1, `alu_res_oe`=1.
- ADD 0xFF+0x01 → 0x00, `flags`=0xB0. Then ADD 0x0F+0x01 → 0x10, `flags`=0x20.
- SUB 0x10−0x20 → 0xF0, `flags`=0x50. CP 0x10,0x10 → `res_data`=0x10, `flags`=0xC0.
- AND 0xF0&0x0F → 0x00, `flags`=0xA0. ADC 0x00+0x00 with C=1 → 0x01 with macro defined, 0x00 without.
- Back-to-back: second `req_valid` held continuously → accepts spaced exactly 4 cycles apart, `req_ready` low for LDA/LO/HI.
- Reset asserted during LO → next cycle in IDLE, `flags`=0x00, `req_ready`=1, no `res_valid` pulse after release.
